inst_fetch_req: RTL and testbench
=================================

Name: inst_fetch_req

Overview:
- Initiator side of the instruction-fetch request/dataOk interface; one instance per way, driving one instruction ROM/I-cache port.
- Owns the way's PC and issues one outstanding request at a time.
- Buffers returned instructions in a small FIFO toward the decode unit.
- Redirects on jump from JumpCtrl and discards stale in-flight responses.

Parameters:
- RESET_PC, 32'h8000_0000, PC loaded at reset.
- PC_STEP, 4, byte increment after each accepted fetch (8 when two ways interleave).
- FIFO_DEPTH, 2, output buffer entries; power of two, >=2.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- jumpFlag_i  in  1  redirect request from JumpCtrl, single-cycle
- jumpAddr_i  in  32  redirect target; bits [1:0] ignored (treated as 0)
- dataOk_i  in  1  memory response strobe, one cycle per request
- inst_fetch_i  in  32  instruction word, valid when dataOk_i=1
- request_o  out  1  fetch request to memory
- instAddr_fetch_o  out  32  fetch address
- inst_o  out  32  FIFO head instruction to DU
- instAddr_o  out  32  PC of FIFO head
- valid_o  out  1  FIFO non-empty
- ready_i  in  1  DU accepts head when valid_o & ready_i

Behaviour:
- Reset (async, reset_n=0):
  - request_o=0, instAddr_fetch_o=RESET_PC, valid_o=0, inst_o=0, instAddr_o=0.
  - pc=RESET_PC, FIFO count=0, state IDLE.
- Memory protocol:
  - While request_o=1, instAddr_fetch_o is held stable until the cycle dataOk_i=1.
  - At most one request is outstanding.
  - request_o may stay high on the cycle after dataOk_i with the next address (back-to-back).
  - dataOk_i while request_o=0 is ignored.
- request_o = (state==FETCH || state==DROP). instAddr_fetch_o = pc in FETCH, stale address in DROP.
- States:
  - IDLE -> FETCH on the first clock after reset release.
  - FETCH, dataOk_i=1, no jump:
    - push {inst_fetch_i, pc}; pc <= pc+PC_STEP (32-bit wrap, no flag).
    - next state FETCH if count_next < FIFO_DEPTH, else WAIT.
  - FETCH, dataOk_i=0: hold.
  - WAIT -> FETCH when count_next < FIFO_DEPTH. A request is only issued when a slot is guaranteed, so a push never overflows.
  - DROP: waiting for the stale response. On dataOk_i, discard the data and go to FETCH with pc = the latched jump target.
- Jump (jumpFlag_i=1):
  - Highest priority: FIFO flushed (count=0, valid_o=0 next cycle); a same-cycle push or pop is cancelled.
  - pc <= {jumpAddr_i[31:2],2'b00}.
  - From FETCH with dataOk_i=0 -> DROP.
  - From FETCH with dataOk_i=1 -> response discarded, -> FETCH at target.
  - From WAIT or IDLE -> FETCH.
  - From DROP -> stay DROP, target overwritten (latest jump wins).
- FIFO:
  - Push and pop in the same cycle leaves count unchanged.
  - Pop on an empty FIFO is impossible, since valid_o gates it.
  - Head outputs are registered with zero-latency read; the first instruction appears on valid_o the cycle after its dataOk_i.
- Latency:
  - reset release -> request_o=1: 1 cycle.
  - jump with no outstanding request -> new address on instAddr_fetch_o next cycle.
- Reset mid-transaction: all state cleared; an in-flight response arriving after reset release is ignored, because request_o=0 in IDLE.

Optional Feature:
- FETCH_PERF_CNT_EN:
  - When defined, adds outputs perf_fetchCnt_o (32) and perf_dropCnt_o (32).
  - perf_fetchCnt_o counts pushed instructions.
  - perf_dropCnt_o counts discarded responses (DROP or same-cycle jump).
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- When undefined, the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package bnine_fetch_pkg:
  - state encoding IDLE=2'd0, FETCH=2'd1, WAIT=2'd2, DROP=2'd3
  - INST_W=32, ADDR_W=32
  - default RESET_PC
- Sub-module fetch_fifo (DEPTH, WIDTH=64): synchronous FIFO with push, pop, flush, count, head; reused for the way1 instance.

Test Plan:
- Reset release, memory returns dataOk 2 cycles after each request, ready_i=1 -> instAddr_fetch_o sequence 0x80000000, 0x80000004, 0x80000008; inst_o/instAddr_o match in order.
- ready_i=0, FIFO_DEPTH=2 -> exactly 2 responses accepted, request_o drops to 0 (WAIT). Raise ready_i one cycle -> request_o=1 next cycle at 0x80000008.
- Jump to 0x80001002 while request for 0x80000004 is outstanding -> request_o stays high at 0x80000004 until dataOk; that data is not pushed; next request is at 0x80001000; valid_o=0 until it returns.
- Jump coincident with dataOk and with a DU pop -> no push; FIFO empty next cycle; request at target next cycle.
- Two jumps (0x100, then 0x200) during DROP -> single stale discard, next fetch at 0x200.
- Assert reset_n=0 mid-request, then release, with a late dataOk_i=1 at 0x80000010 -> ignored, fetch restarts at 0x80000000. With FETCH_PERF_CNT_EN, counters read 0 after reset and drop count increments once per jump-discard scenario above.

Source files
------------

// File: rtl/bnine_fetch_pkg.sv
// Shared types and constants for the instruction-fetch request path.
// Used by inst_fetch_req and its fetch_fifo output buffer.
package bnine_fetch_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h8000_0000;

  // Fetch controller states; the encoding is shared with the way1 instance
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    DROP  = 2'd3
  } fetch_state_e;

  // One buffered instruction together with the PC it was fetched from
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] addr;
  } fetch_entry_t;

  // Jump targets are word aligned; the two low address bits are forced to zero
  function automatic logic [ADDR_W-1:0] alignWord(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched instructions for the decode unit.
// The head entry is read straight out of the storage registers, so an entry
// written on one clock is visible on head_o right after that clock.
// flush_i has priority over push_i and pop_i in the same cycle.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [WIDTH-1:0]       data_i,
  output logic [WIDTH-1:0]       head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wrPtr_q, wrPtr_d;
  logic [PW-1:0]    rdPtr_q, rdPtr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             doPush;
  logic             doPop;

  assign doPop  = pop_i & ~flush_i & (count_q != '0);
  assign doPush = push_i & ~flush_i & ((count_q != DEPTH_C) | doPop);

  // Pointer and occupancy update; a flush empties the buffer without touching data
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + PW'(1);
      if (doPop)  rdPtr_d = rdPtr_q + PW'(1);
      count_d = count_q + CW'(doPush) - CW'(doPop);
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage is cleared on reset so the head reads as zero until the first push
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (doPush) begin
      mem_q[wrPtr_q] <= data_i;
    end
  end

  assign head_o  = mem_q[rdPtr_q];
  assign count_o = count_q;

endmodule

// File: rtl/inst_fetch_req.sv
// Instruction-fetch request initiator for one way: owns the PC, keeps one
// request outstanding toward the instruction memory, buffers returned words
// for decode and redirects on jumps, discarding stale in-flight responses.
// Optional macro FETCH_PERF_CNT_EN adds saturating fetch/drop counters.
module inst_fetch_req
  import bnine_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter logic [ADDR_W-1:0] PC_STEP    = 32'd4,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              jumpFlag_i,
  input  logic [ADDR_W-1:0] jumpAddr_i,
  input  logic              dataOk_i,
  input  logic [INST_W-1:0] inst_fetch_i,
  output logic              request_o,
  output logic [ADDR_W-1:0] instAddr_fetch_o,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] instAddr_o,
  output logic              valid_o,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]       perf_fetchCnt_o,
  output logic [31:0]       perf_dropCnt_o,
`endif
  input  logic              ready_i
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] staleAddr_q, staleAddr_d;

  logic [ADDR_W-1:0] jumpTarget;
  logic              fifoPush;
  logic              fifoPop;
  logic [CW-1:0]     fifoCount;
  logic [CW-1:0]     countNext;
  logic              slotFree;
  logic              discard;
  fetch_entry_t      pushEntry;
  fetch_entry_t      headEntry;

  assign jumpTarget = alignWord(jumpAddr_i);

  // A jump cancels both the push of a coinciding response and the decode pop
  assign fifoPush  = (state_q == FETCH) & dataOk_i & ~jumpFlag_i;
  assign fifoPop   = valid_o & ready_i & ~jumpFlag_i;
  assign countNext = jumpFlag_i ? '0 : (fifoCount + CW'(fifoPush) - CW'(fifoPop));
  assign slotFree  = (countNext < DEPTH_C);
  assign discard   = dataOk_i & ((state_q == DROP) | ((state_q == FETCH) & jumpFlag_i));

  assign pushEntry = '{inst: inst_fetch_i, addr: pc_q};

  // Next-state, PC and stale-address selection; jumps take priority everywhere
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    staleAddr_d = staleAddr_q;
    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (jumpFlag_i) pc_d = jumpTarget;
      end
      FETCH: begin
        if (jumpFlag_i) begin
          pc_d = jumpTarget;
          if (dataOk_i) begin
            state_d = FETCH;
          end else begin
            staleAddr_d = pc_q;
            state_d     = DROP;
          end
        end else if (dataOk_i) begin
          pc_d    = pc_q + PC_STEP;
          state_d = slotFree ? FETCH : WAIT;
        end
      end
      WAIT: begin
        if (jumpFlag_i) begin
          pc_d    = jumpTarget;
          state_d = FETCH;
        end else if (slotFree) begin
          state_d = FETCH;
        end
      end
      DROP: begin
        // A jump landing on the stale response cycle still retires that
        // response, otherwise the way would wait forever for a second one.
        if (jumpFlag_i) pc_d = jumpTarget;
        if (dataOk_i) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller state, PC and stale-request address registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      staleAddr_q <= RESET_PC;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      staleAddr_q <= staleAddr_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (fifoPush),
    .pop_i   (fifoPop),
    .flush_i (jumpFlag_i),
    .data_i  (pushEntry),
    .head_o  (headEntry),
    .count_o (fifoCount)
  );

  assign request_o        = (state_q == FETCH) | (state_q == DROP);
  assign instAddr_fetch_o = (state_q == DROP) ? staleAddr_q : pc_q;
  assign valid_o          = (fifoCount != '0);
  assign inst_o           = headEntry.inst;
  assign instAddr_o       = headEntry.addr;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetchCnt_q, fetchCnt_d;
  logic [31:0] dropCnt_q, dropCnt_d;

  // Saturating event counts for pushed and discarded responses
  always_comb begin
    fetchCnt_d = fetchCnt_q;
    dropCnt_d  = dropCnt_q;
    if (fifoPush && (fetchCnt_q != 32'hFFFF_FFFF)) fetchCnt_d = fetchCnt_q + 32'd1;
    if (discard && (dropCnt_q != 32'hFFFF_FFFF))   dropCnt_d  = dropCnt_q + 32'd1;
  end

  // Performance counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetchCnt_q <= '0;
      dropCnt_q  <= '0;
    end else begin
      fetchCnt_q <= fetchCnt_d;
      dropCnt_q  <= dropCnt_d;
    end
  end

  assign perf_fetchCnt_o = fetchCnt_q;
  assign perf_dropCnt_o  = dropCnt_q;
`else
  logic unusedDiscard;
  assign unusedDiscard = discard;
`endif

endmodule

// File: tb/tb_inst_fetch_req.sv
// Self-checking bench for inst_fetch_req: a hand-derived vector table, a
// mid-transaction reset sequence and a randomized run against a queue-based
// reference model. Honours FETCH_PERF_CNT_EN when defined.
module tb_inst_fetch_req;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] STEP     = 32'd4;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        jumpFlag = 1'b0;
  logic [31:0] jumpAddr = '0;
  logic        dataOk = 1'b0;
  logic [31:0] instFetch = '0;
  logic        ready = 1'b0;
  logic        request;
  logic [31:0] instAddrFetch;
  logic [31:0] inst;
  logic [31:0] instAddr;
  logic        valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perfFetch;
  logic [31:0] perfDrop;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  inst_fetch_req #(
    .RESET_PC   (RESET_PC),
    .PC_STEP    (STEP),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .jumpFlag_i       (jumpFlag),
    .jumpAddr_i       (jumpAddr),
    .dataOk_i         (dataOk),
    .inst_fetch_i     (instFetch),
    .request_o        (request),
    .instAddr_fetch_o (instAddrFetch),
    .inst_o           (inst),
    .instAddr_o       (instAddr),
    .valid_o          (valid),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetchCnt_o  (perfFetch),
    .perf_dropCnt_o   (perfDrop),
`endif
    .ready_i          (ready)
  );

  typedef struct {
    logic        jf;
    logic [31:0] ja;
    logic        dok;
    logic [31:0] data;
    logic        rdy;
    logic        expReq;
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expInst;
    logic [31:0] expIAddr;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
  } entry_t;

  vec_t vecs[$];

  // reference model: abstract view of the way
  bit          mStarted;
  logic [31:0] mPc;
  bit          mStale;
  logic [31:0] mStaleAddr;
  entry_t      mq[$];
  int          mFetches;
  int          mDrops;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic jf, input logic [31:0] ja, input logic dok,
                               input logic [31:0] data, input logic rdy);
    jumpFlag  = jf;
    jumpAddr  = ja;
    dataOk    = dok;
    instFetch = data;
    ready     = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkVisible(input string tag, input logic eReq, input logic [31:0] eAddr,
                              input logic eValid, input logic [31:0] eInst, input logic [31:0] eIAddr);
    checkOutput({tag, " request_o"}, {31'b0, request}, {31'b0, eReq});
    checkOutput({tag, " instAddr_fetch_o"}, instAddrFetch, eAddr);
    checkOutput({tag, " valid_o"}, {31'b0, valid}, {31'b0, eValid});
    if (eValid) begin
      checkOutput({tag, " inst_o"}, inst, eInst);
      checkOutput({tag, " instAddr_o"}, instAddr, eIAddr);
    end
  endtask

  function automatic bit modelReq();
    return mStarted && (mStale || (mq.size() < DEPTH));
  endfunction

  function automatic void modelReset();
    mStarted = 0;
    mPc      = RESET_PC;
    mStale   = 0;
    mStaleAddr = RESET_PC;
    mq.delete();
    mFetches = 0;
    mDrops   = 0;
  endfunction

  // advance the model by one clock with the inputs presented before that clock
  function automatic void modelStep(input logic jf, input logic [31:0] ja, input logic dok,
                                    input logic [31:0] data, input logic rdy);
    bit req;
    logic [31:0] target;
    target = ja & 32'hFFFF_FFFC;
    if (!mStarted) begin
      mStarted = 1;
      if (jf) mPc = target;
      return;
    end
    req = modelReq();
    if (jf) begin
      mq.delete();
      if (req && dok) begin
        mStale = 0;
        mDrops++;
      end else if (req && !mStale) begin
        mStale = 1;
        mStaleAddr = mPc;
      end
      mPc = target;
    end else begin
      if (rdy && (mq.size() > 0)) void'(mq.pop_front());
      if (req && dok) begin
        if (mStale) begin
          mStale = 0;
          mDrops++;
        end else begin
          mq.push_back('{data, mPc});
          mPc = mPc + STEP;
          mFetches++;
        end
      end
    end
  endfunction

  function automatic logic [31:0] modelAddr();
    return mStale ? mStaleAddr : mPc;
  endfunction

  initial begin
    int memCnt;
    int memLat;
    logic jf, dok, rdy;
    logic [31:0] ja, data;
    entry_t hd;

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    checkVisible("reset", 1'b0, RESET_PC, 1'b0, 32'h0, 32'h0);
    checkOutput("reset inst_o", inst, 32'h0);
    checkOutput("reset instAddr_o", instAddr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    checkOutput("reset perf_fetchCnt", perfFetch, 32'h0);
    checkOutput("reset perf_dropCnt", perfDrop, 32'h0);
`endif
    reset_n = 1'b1;

    // ---------------- vector table ----------------
    //                jf  ja            dok data          rdy  req addr          vld inst          iaddr
    vecs.push_back('{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'h8000_0000, 1'b0, 32'h0,        32'h0});
    vecs.push_back('{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'h8000_0000, 1'b0, 32'h0,        32'h0});
    vecs.push_back('{1'b0, 32'h0,        1'b1, 32'h1111_1111, 1'b1, 1'b1, 32'h8000_0004, 1'b1, 32'h1111_1111, 32'h8000_0000});
    vecs.push_back('{1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 32'h8000_0004, 1'b0, 32'h0,        32'h0});
    vecs.push_back('{1'b0, 32'h0,        1'b1, 32'h2222_2222, 1'b0, 1'b1, 32'h8000_0008, 1'b1, 32'h2222_2222, 32'h8000_0004});
    vecs.push_back('{1'b0, 32'h0,        1'b1, 32'h3333_3333, 1'b0, 1'b0, 32'h8000_000C, 1'b1, 32'h2222_2222, 32'h8000_0004});
    vecs.push_back('{1'b0, 32'h0,        1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, 32'h8000_000C, 1'b1, 32'h2222_2222, 32'h8000_0004});
    vecs.push_back('{1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 32'h8000_000C, 1'b1, 32'h3333_3333, 32'h8000_0008});
    vecs.push_back('{1'b1, 32'h8000_1002, 1'b0, 32'h0,        1'b1, 1'b1, 32'h8000_000C, 1'b0, 32'h0,        32'h0});
    vecs.push_back('{1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 32'h8000_000C, 1'b0, 32'h0,        32'h0});
    vecs.push_back('{1'b0, 32'h0,        1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h8000_1000, 1'b0, 32'h0,        32'h0});
    vecs.push_back('{1'b0, 32'h0,        1'b1, 32'h4444_4444, 1'b1, 1'b1, 32'h8000_1004, 1'b1, 32'h4444_4444, 32'h8000_1000});
    vecs.push_back('{1'b1, 32'h0000_0100, 1'b1, 32'h5555_5555, 1'b1, 1'b1, 32'h0000_0100, 1'b0, 32'h0,        32'h0});
    vecs.push_back('{1'b1, 32'h0000_0300, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0100, 1'b0, 32'h0,        32'h0});
    vecs.push_back('{1'b1, 32'h0000_0201, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0100, 1'b0, 32'h0,        32'h0});
    vecs.push_back('{1'b0, 32'h0,        1'b1, 32'h6666_6666, 1'b1, 1'b1, 32'h0000_0200, 1'b0, 32'h0,        32'h0});
    vecs.push_back('{1'b0, 32'h0,        1'b1, 32'h7777_7777, 1'b0, 1'b1, 32'h0000_0204, 1'b1, 32'h7777_7777, 32'h0000_0200});

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].jf, vecs[i].ja, vecs[i].dok, vecs[i].data, vecs[i].rdy);
      checkVisible($sformatf("vec%0d", i), vecs[i].expReq, vecs[i].expAddr,
                   vecs[i].expValid, vecs[i].expInst, vecs[i].expIAddr);
    end
`ifdef FETCH_PERF_CNT_EN
    checkOutput("table perf_fetchCnt", perfFetch, 32'd5);
    checkOutput("table perf_dropCnt", perfDrop, 32'd3);
`endif

    // ---------------- reset in the middle of a request ----------------
    jumpFlag = 1'b0;
    dataOk   = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    checkVisible("midreset", 1'b0, RESET_PC, 1'b0, 32'h0, 32'h0);
    checkOutput("midreset inst_o", inst, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    checkOutput("midreset perf_fetchCnt", perfFetch, 32'h0);
    checkOutput("midreset perf_dropCnt", perfDrop, 32'h0);
`endif
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1, 32'hBAD0_0010, 1'b1);
    checkVisible("late dataOk", 1'b1, RESET_PC, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checkVisible("restart hold", 1'b1, RESET_PC, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'hCAFE_0001, 1'b0);
    checkVisible("restart first", 1'b1, RESET_PC + 32'd4, 1'b1, 32'hCAFE_0001, RESET_PC);

    // ---------------- randomized run against the model ----------------
    reset_n = 1'b0;
    jumpFlag = 1'b0;
    dataOk = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    modelReset();
    memCnt = 0;
    memLat = $urandom_range(0, 3);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      jf   = ($urandom_range(0, 19) == 0);
      ja   = $urandom;
      rdy  = ($urandom_range(0, 1) == 1);
      data = $urandom;
      if (request) begin
        if (memCnt >= memLat) begin
          dok    = 1'b1;
          memCnt = 0;
          memLat = $urandom_range(0, 3);
        end else begin
          dok = 1'b0;
          memCnt++;
        end
      end else begin
        dok    = ($urandom_range(0, 7) == 0);
        memCnt = 0;
      end
      modelStep(jf, ja, dok, data, rdy);
      applyStimulus(jf, ja, dok, data, rdy);
      if (mq.size() > 0) hd = mq[0];
      else hd = '{32'h0, 32'h0};
      checkVisible($sformatf("rand%0d", cyc), modelReq(), modelAddr(),
                   (mq.size() > 0), hd.data, hd.addr);
    end
`ifdef FETCH_PERF_CNT_EN
    checkOutput("rand perf_fetchCnt", perfFetch, mFetches);
    checkOutput("rand perf_dropCnt", perfDrop, mDrops);
`endif
    $display("[TB] random run: %0d pushes, %0d drops in model", mFetches, mDrops);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
